// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DFFRAM (1-cycle registered read).
// Grants are combinational; each response is routed back to its issuing port one cycle later.
module dffram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          P0_REQ,
  input  logic [3:0]    P0_WE,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [DW-1:0] P0_WDATA,
  output logic          P0_GNT,
  output logic          P0_RVALID,
  output logic [DW-1:0] P0_RDATA,
  input  logic          P1_REQ,
  input  logic [3:0]    P1_WE,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [DW-1:0] P1_WDATA,
  output logic          P1_GNT,
  output logic          P1_RVALID,
  output logic [DW-1:0] P1_RDATA,
  output logic          RAM_EN,
  output logic [3:0]    RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);
  localparam int NP = 2;

  typedef struct packed {
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, RSP0, RSP1} state_t;

  req_t   [NP-1:0]         preq;
  logic   [NP-1:0]         req, gnt, rvalid;
  logic   [NP-1:0][DW-1:0] rdata;
  logic                    last, sel, rsp_vld, rsp_id;
  state_t                  state, state_nxt;

  assign preq[0] = '{we: P0_WE, addr: P0_ADDR, wdata: P0_WDATA};
  assign preq[1] = '{we: P1_WE, addr: P1_ADDR, wdata: P1_WDATA};

  // Requests are masked during reset so nothing reaches the RAM.
  assign req    = {P1_REQ, P0_REQ} & {NP{~RST}};
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
  assign sel    = gnt[1];

  // With no grant sel is 0, so the RAM pins follow port 0.
  assign RAM_EN = |gnt;
  assign RAM_WE = preq[sel].we;
  assign RAM_A  = preq[sel].addr;
  assign RAM_DI = preq[sel].wdata;

  always_ff @(posedge CLK) begin
    if (RST)       last <= 1'b1;
    else if (|gnt) last <= sel;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (gnt[0])      state_nxt = RSP0;
    else if (gnt[1]) state_nxt = RSP1;
  end

  assign rsp_vld = (state != IDLE);
  assign rsp_id  = (state == RSP1);

  // RST gating drops a response that was pending when reset arrived.
  for (genvar i = 0; i < NP; i++) begin : g_rsp
    assign rvalid[i] = rsp_vld & (rsp_id == 1'(i)) & ~RST;
    assign rdata[i]  = rvalid[i] ? RAM_DO : '0;
  end

  assign P0_GNT    = gnt[0];
  assign P1_GNT    = gnt[1];
  assign P0_RVALID = rvalid[0];
  assign P1_RVALID = rvalid[1];
  assign P0_RDATA  = rdata[0];
  assign P1_RDATA  = rdata[1];
endmodule

// File: tb/tb_dffram_arbiter.sv
// Bench for dffram_arbiter: DFFRAM stand-in plus a transaction-level reference model
// (winner rule, pending-response record and a shadow memory), directed then random steps.
module tb_dffram_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req[2];
  logic [3:0]  we[2];
  logic [11:0] addr[2];
  logic [31:0] wdata[2];
  logic        gnt0, gnt1, rv0, rv1, ram_en;
  logic [31:0] rd0, rd1, ram_di, ram_do;
  logic [3:0]  ram_we;
  logic [11:0] ram_a;

  logic [31:0] ram[0:4095];
  logic [31:0] ref_mem[0:4095];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_last;
  bit          pend_v;
  int          pend_p;
  logic [31:0] pend_d;
  logic        obs_gnt[2];
  logic        obs_rv[2];
  logic [31:0] obs_rd[2];
  logic        obs_en;
  bit          hold[2];
  logic [5:0]  seq;

  dffram_arbiter #(.AW(12), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .P0_REQ(req[0]), .P0_WE(we[0]), .P0_ADDR(addr[0]), .P0_WDATA(wdata[0]),
    .P0_GNT(gnt0), .P0_RVALID(rv0), .P0_RDATA(rd0),
    .P1_REQ(req[1]), .P1_WE(we[1]), .P1_ADDR(addr[1]), .P1_WDATA(wdata[1]),
    .P1_GNT(gnt1), .P1_RVALID(rv1), .P1_RDATA(rd1),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_DI(ram_di), .RAM_DO(ram_do)
  );

  always #5 CLK = ~CLK;

  // DFFRAM stand-in: registered read, read-before-write, byte mask, no reset.
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= ram[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic drive(input int p, input logic r, input logic [3:0] w,
                       input logic [11:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic idle();
    req[0] = 1'b0; req[1] = 1'b0;
  endtask

  // One clock: sample at negedge, check against the model, advance the model, return #1 after posedge.
  task automatic cycle();
    int          w, m;
    logic        erv[2];
    logic [31:0] erd[2];
    @(negedge CLK);
    w = -1;
    if (!RST) begin
      if (req[0] && req[1]) w = 1 - m_last;
      else if (req[0])      w = 0;
      else if (req[1])      w = 1;
    end
    m = (w < 0) ? 0 : w;
    chk("gnt0",    32'(gnt0), 32'(w == 0));
    chk("gnt1",    32'(gnt1), 32'(w == 1));
    chk("onehot",  32'(gnt0 & gnt1), 32'd0);
    chk("ram_en",  32'(ram_en), 32'(w >= 0));
    if (!RST) begin
      chk("ram_a",  32'(ram_a),  32'(addr[m]));
      chk("ram_we", 32'(ram_we), 32'(we[m]));
      chk("ram_di", ram_di, wdata[m]);
    end
    for (int p = 0; p < 2; p++) begin
      erv[p] = pend_v && (pend_p == p) && !RST;
      erd[p] = erv[p] ? pend_d : 32'd0;
    end
    chk("rvalid0", 32'(rv0), 32'(erv[0]));
    chk("rvalid1", 32'(rv1), 32'(erv[1]));
    chk("rdata0",  rd0, erd[0]);
    chk("rdata1",  rd1, erd[1]);
    obs_gnt[0] = gnt0; obs_gnt[1] = gnt1;
    obs_rv[0]  = rv0;  obs_rv[1]  = rv1;
    obs_rd[0]  = rd0;  obs_rd[1]  = rd1;
    obs_en     = ram_en;
    if (RST) begin
      m_last = 1;
      pend_v = 1'b0;
    end else begin
      pend_v = (w >= 0);
      if (w >= 0) begin
        m_last = w;
        pend_p = w;
        pend_d = ref_mem[addr[w]];
        for (int b = 0; b < 4; b++)
          if (we[w][b]) ref_mem[addr[w]][8*b +: 8] = wdata[w][8*b +: 8];
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    idle();
    repeat (n) cycle();
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
    ram_do = 32'd0;
    m_last = 1; pend_v = 1'b0; pend_p = 0; pend_d = 32'd0;
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 4'h0, 12'h0, 32'h0);

    // Reset state, then a single port-0 read.
    do_reset(2);
    chk("rst_rvalid0", 32'(obs_rv[0]), 32'd0);
    chk("rst_rdata0",  obs_rd[0], 32'd0);
    preload(12'h010, 32'hDEADBEEF);
    drive(0, 1'b1, 4'h0, 12'h010, 32'h0);
    cycle();
    chk("t1_gnt0", 32'(obs_gnt[0]), 32'd1);
    chk("t1_en",   32'(obs_en), 32'd1);
    idle();
    cycle();
    chk("t1_rv0", 32'(obs_rv[0]), 32'd1);
    chk("t1_rd0", obs_rd[0], 32'hDEADBEEF);
    chk("t1_rv1", 32'(obs_rv[1]), 32'd0);

    // Continuous contention right after reset alternates 0,1,0,1,0,1.
    do_reset(1);
    drive(0, 1'b1, 4'h0, 12'h010, 32'h0);
    drive(1, 1'b1, 4'h0, 12'h011, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      seq[i] = obs_gnt[1];
    end
    chk("t2_seq", 32'(seq), 32'(6'b101010));
    idle();
    cycle();

    // Masked write by port 1, then port 0 reads the merged word.
    preload(12'h020, 32'hAAAAAAAA);
    drive(1, 1'b1, 4'b0101, 12'h020, 32'h11223344);
    cycle();
    chk("t3_gnt1", 32'(obs_gnt[1]), 32'd1);
    idle();
    drive(0, 1'b1, 4'h0, 12'h020, 32'h0);
    cycle();
    chk("t3_wack", 32'(obs_rv[1]), 32'd1);
    idle();
    cycle();
    chk("t3_rd0", obs_rd[0], 32'hAA22AA44);

    // Reset right after a read grant drops the response; port 0 wins next contention.
    drive(0, 1'b1, 4'h0, 12'h010, 32'h0);
    cycle();
    idle();
    RST = 1'b1;
    cycle();
    chk("t4_rv0_drop", 32'(obs_rv[0]), 32'd0);
    RST = 1'b0;
    cycle();
    chk("t4_rv0_after", 32'(obs_rv[0]), 32'd0);
    drive(0, 1'b1, 4'h0, 12'h010, 32'h0);
    drive(1, 1'b1, 4'h0, 12'h011, 32'h0);
    cycle();
    chk("t4_first", 32'(obs_gnt[0]), 32'd1);
    idle();
    cycle();

    // Port 1 alone three times, then contention goes to port 0; then idle.
    req[0] = 1'b0;
    drive(1, 1'b1, 4'h0, 12'h030, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_solo1", 32'(obs_gnt[1]), 32'd1);
    end
    drive(0, 1'b1, 4'h0, 12'h031, 32'h0);
    cycle();
    chk("t5_cont0", 32'(obs_gnt[0]), 32'd1);
    idle();
    cycle();
    cycle();
    chk("t5_idle_en", 32'(obs_en), 32'd0);
    chk("t5_idle_rv", 32'({obs_rv[1], obs_rv[0]}), 32'd0);

    // Random traffic on a small address window; requests held until granted.
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        if (!hold[p]) begin
          req[p]   = ($urandom_range(0, 99) < 60);
          we[p]    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          addr[p]  = 12'h100 + 12'($urandom_range(0, 7));
          wdata[p] = $urandom;
        end
      RST = ($urandom_range(0, 99) < 3);
      cycle();
      for (int p = 0; p < 2; p++) hold[p] = req[p] && !obs_gnt[p];
    end
    RST = 1'b0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
